snn_run_scheduler: RTL

Sequencer that owns the `neural_network` SNN core and runs queued inference requests on it one at a time. For each run it:
- resets the core,
- applies the 2-bit input,
- pulses start,
- waits for done under a timeout,
- captures spike_count,
- returns a thresholded class with the requester's tag.

It sits between the host-side request/response interfaces and the single `neural_network` instance.

---
 rtl/snn_run_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/snn_run_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snn_run_scheduler
// Description : Queues inference requests and runs them one at a time on a
//               single neural_network core: reset core, settle, load inputs,
//               pulse start, wait for done (with timeout), and return a
//               thresholded class tagged with the requester's tag.
// Ports       : clk/reset          - clock, synchronous active-high reset
//               req_*              - request valid/ready, inputs, tag
//               rsp_*              - response valid/ready, tag, count, class,
//                                    timeout flag
//               nn_*               - core reset/start/inputs, done/spike count
//               busy               - FSM active or requests queued
//               timeout_count      - saturating number of abandoned runs
// Revision    : 1.0 - initial release
// ============================================================================
module snn_run_scheduler #(
  parameter int QDEPTH        = 4,
  parameter int RST_CYCLES    = 5,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 50,
  parameter int THRESH        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_inputs,
  input  logic [3:0] req_tag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_tag,
  output logic [7:0] rsp_count,
  output logic       rsp_class,
  output logic       rsp_timeout,
  output logic       nn_reset,
  output logic       nn_start,
  output logic [1:0] nn_inputs,
  input  logic       nn_done,
  input  logic [7:0] nn_spike_count,
  output logic       busy,
  output logic [7:0] timeout_count
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] LOAD   = 3'd3;
  localparam logic [2:0] START  = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] RESP   = 3'd6;

  // Last-cycle values of the shared phase counter for each timed state.
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
  localparam logic [7:0]  THRESH_V    = 8'(THRESH);

  logic [2:0]    state, next_state;

  // Request FIFO, entries are {tag, inputs}.
  logic [5:0]    mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop;

  logic [15:0]   phase_cnt;
  logic [3:0]    run_tag;
  logic [1:0]    run_inputs;
  logic [1:0]    inputs_q;
  logic [3:0]    tag_q;
  logic [7:0]    count_q;
  logic          class_q, timeout_q;
  logic [7:0]    tcount_q;

  assign fifo_full  = (fifo_cnt == (AW+1)'(QDEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = req_valid && req_ready;
  assign pop        = (state == IDLE) && !fifo_empty && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {req_tag, req_inputs};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!fifo_empty) next_state = CLEAR;
      CLEAR:  if (phase_cnt == RST_LAST)
                next_state = (SETTLE_CYCLES == 0) ? LOAD : SETTLE;
      SETTLE: if (phase_cnt == SETTLE_LAST) next_state = LOAD;
      LOAD:   next_state = START;
      START:  next_state = WAIT;
      // done on the last allowed cycle wins over the timeout
      WAIT:   if (nn_done || (phase_cnt == TO_LAST)) next_state = RESP;
      RESP:   if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: phase counter, run registers, captured result
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt  <= '0;
      run_tag    <= '0;
      run_inputs <= '0;
      inputs_q   <= '0;
      tag_q      <= '0;
      count_q    <= '0;
      class_q    <= 1'b0;
      timeout_q  <= 1'b0;
      tcount_q   <= '0;
    end else begin
      // counter restarts on every state change so each phase counts from 0
      if (state != next_state) phase_cnt <= '0;
      else                     phase_cnt <= phase_cnt + 16'd1;

      if (pop) begin
        {run_tag, run_inputs} <= mem[rd_ptr];
      end

      if ((next_state == LOAD) && (state != LOAD)) begin
        inputs_q <= run_inputs;
      end

      if (state == WAIT) begin
        if (nn_done) begin
          tag_q     <= run_tag;
          count_q   <= nn_spike_count;
          class_q   <= (nn_spike_count >= THRESH_V);
          timeout_q <= 1'b0;
        end else if (phase_cnt == TO_LAST) begin
          tag_q     <= run_tag;
          count_q   <= '0;
          class_q   <= 1'b0;
          timeout_q <= 1'b1;
          if (tcount_q != 8'hFF) tcount_q <= tcount_q + 8'd1;
        end
      end
    end
  end

  // Outputs; everything is forced to its idle value while reset is high,
  // before the state register has had an edge to clear.
  always_comb begin
    req_ready     = !fifo_full && !reset;
    nn_reset      = reset || (state == CLEAR);
    nn_start      = !reset && (state == START);
    rsp_valid     = !reset && (state == RESP);
    busy          = !reset && ((state != IDLE) || !fifo_empty);
    nn_inputs     = reset ? 2'b00 : inputs_q;
    rsp_tag       = reset ? 4'h0  : tag_q;
    rsp_count     = reset ? 8'h00 : count_q;
    rsp_class     = !reset && class_q;
    rsp_timeout   = !reset && timeout_q;
    timeout_count = reset ? 8'h00 : tcount_q;
  end

endmodule
`default_nettype wire
